// File: rtl/addertree_pkg.sv
// Shared types and default sizing for the adder-tree accumulation blocks.
package addertree_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } accum_state_e;

    localparam int ADDERTREE_DEF_ELEMENTS = 52;
    localparam int ADDERTREE_DEF_WIDTH    = 32;

endpackage

// File: rtl/addertree_accum_ctrl_tree.sv
// Combinational 3:2 carry-save reduction of NUM_ELEMENTS lanes to one sum, modulo 2^DATA_WIDTH.
// The clk port exists for interface compatibility only and drives nothing.
module AdderTree3to2 #(
    parameter int NUM_ELEMENTS = 52,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] in_data_i [NUM_ELEMENTS],
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic unused_clk_s;
    assign unused_clk_s = clk;

    // Fold each lane into a sum/carry pair, then resolve with one carry-propagate add
    always_comb begin
        logic [DATA_WIDTH-1:0] sv_s;
        logic [DATA_WIDTH-1:0] cv_s;
        logic [DATA_WIDTH-1:0] xv_s;
        logic [DATA_WIDTH-1:0] maj_s;
        sv_s  = in_data_i[0];
        cv_s  = in_data_i[1];
        xv_s  = '0;
        maj_s = '0;
        for (int i = 2; i < NUM_ELEMENTS; i++) begin
            xv_s  = sv_s ^ cv_s ^ in_data_i[i];
            maj_s = (sv_s & cv_s) | (sv_s & in_data_i[i]) | (cv_s & in_data_i[i]);
            sv_s  = xv_s;
            cv_s  = {maj_s[DATA_WIDTH-2:0], 1'b0};
        end
        sum_o = sv_s + cv_s;
    end

endmodule

// File: rtl/addertree_accum_ctrl.sv
// Accumulates a multi-beat vector: each beat is reduced by one adder tree, beat sums are
// registered and summed across beats, and the total is offered on a valid/ready output.
module addertree_accum_ctrl
    import addertree_pkg::*;
#(
    parameter int NUM_ELEMENTS = ADDERTREE_DEF_ELEMENTS,
    parameter int DATA_WIDTH   = ADDERTREE_DEF_WIDTH,
    parameter int MAX_BEATS    = 16,
    parameter int CNT_W        = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_ELEMENTS],
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]      out_beats,
    output logic                  out_trunc
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BEATS);
    localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

    accum_state_e          state_q, state_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_sum_q;
    logic [CNT_W-1:0]      out_beats_q;
    logic                  out_trunc_q;

    logic [DATA_WIDTH-1:0] psum_q;
    logic                  psum_vld_q;
    logic                  psum_last_q;
    logic                  psum_trunc_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic                  first_q;

    logic [DATA_WIDTH-1:0] tree_sum_s;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic [CNT_W:0]        cnt_inc_s;
    logic                  at_limit_s;
    logic                  beat_final_s;
    logic [DATA_WIDTH-1:0] acc_sum_s;

    AdderTree3to2 #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_tree (
        .clk       (clk),
        .in_data_i (in_data),
        .sum_o     (tree_sum_s)
    );

    assign in_fire_s    = in_valid && in_ready_q;
    assign out_fire_s   = out_valid_q && out_ready;
    assign cnt_inc_s    = {1'b0, beat_cnt_q} + CNT_ONE;
    assign at_limit_s   = (cnt_inc_s == MAX_CNT);
    assign beat_final_s = in_last || at_limit_s;
    // The first beat of a vector starts from zero rather than the stale accumulator
    assign acc_sum_s    = (first_q ? '0 : acc_q) + psum_q;

    // Next-state logic for the beat/drain/output sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (in_fire_s && beat_final_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_fire_s) begin
                    state_d = ACCUM;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == OUT);
        end
    end

    // Stage 1: capture the reduced beat and the beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psum_q       <= '0;
            psum_vld_q   <= 1'b0;
            psum_last_q  <= 1'b0;
            psum_trunc_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            psum_vld_q <= in_fire_s;
            if (in_fire_s) begin
                psum_q       <= tree_sum_s;
                psum_last_q  <= beat_final_s;
                psum_trunc_q <= !in_last && at_limit_s;
                beat_cnt_q   <= cnt_inc_s[CNT_W-1:0];
            end else if (psum_vld_q && psum_last_q) begin
                beat_cnt_q <= '0;
            end
        end
    end

    // Stage 2: accumulate beat sums and latch the result on the closing beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_trunc_q <= 1'b0;
        end else if (psum_vld_q) begin
            acc_q   <= acc_sum_s;
            first_q <= psum_last_q;
            if (psum_last_q) begin
                out_sum_q   <= acc_sum_s;
                out_beats_q <= beat_cnt_q;
                out_trunc_q <= psum_trunc_q;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_trunc = out_trunc_q;

endmodule
